shift_sequencer: RTL
====================

Name: shift_sequencer

Overview:
- Multi-cycle iterative shift controller for the multi-cycle MIPS datapath.
- Accepts an R-type shift request (funct, shamt, rs, rt) and decodes the shift kind and amount source (shamt or rs[4:0]).
- Shifts rt by up to STEP bits per cycle under a 3-state FSM, then pulses done with the result.
- Used by the main control FSM in place of a single-cycle barrel shifter.

Parameters:
- WIDTH, 32, data width of rt_val/result (fixed 32 for MIPS; amount field is 5 bits).
- STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8; other values are an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- funct  in  6  R-type function code.
- shamt  in  5  immediate shift amount.
- rs_val  in  WIDTH  rs operand; bits [4:0] give the variable amount.
- rt_val  in  WIDTH  value to shift.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse, coincident with done, for a non-shift funct.
- result  out  WIDTH  shifted value; stable from done until the next accepted start.

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, illegal=0, result=0, count=0.
- Funct decode:
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: amount = shamt.
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: amount = rs_val[4:0].
  - Any other funct is illegal.
- IDLE, start=1 (edge k):
  - Latch op, direction, arithmetic flag, and amount N into count.
  - Load result=rt_val.
  - If illegal or N=0, go to DONE; otherwise go to SHIFT.
- SHIFT (each edge):
  - s = min(STEP, count).
  - result shifted by s: left fills zeros; SRL fills zeros; SRA replicates result[WIDTH-1].
  - count -= s.
  - If count reaches 0, go to DONE.
- DONE:
  - done=1 for exactly one cycle; illegal=1 in the same cycle if the request was illegal.
  - Next edge goes to IDLE.
- Latency: done is high in the cycle after edge k+ceil(N/STEP). Examples: N=0 or illegal gives 1 cycle; N=31 with STEP=1 gives 32 cycles.
- Input capture: funct, shamt, rs_val and rt_val are sampled only at accept. Later changes have no effect.
- start while busy (SHIFT or DONE): ignored, not queued. start is accepted again from IDLE only, i.e. one cycle after done at the earliest.
- Illegal request: result=rt_val unchanged, no shift cycles.
- Reset mid-operation: the operation is dropped, outputs take reset values, and no done is produced.
- done and illegal are registered outputs, not combinational from inputs.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in SHIFT or DONE: next edge goes to IDLE, result=0, and no done (a done pending in that cycle is suppressed).
  - abort in IDLE has no effect; abort has priority over start.
- Undefined: port abort is absent; every accepted request completes with done.

Decomposition:
- Package shift_seq_pkg:
  - Funct constants FUNCT_SLL/SRL/SRA/SLLV/SRLV/SRAV.
  - State enum {IDLE, SHIFT, DONE}.
  - Op enum {OP_LEFT, OP_RIGHT_LOG, OP_RIGHT_ARITH}.
  - Legal-STEP check function.
- Sub-module shift_step:
  - Combinational; shifts by 0..STEP bits in the given direction with arithmetic fill.
  - Instantiated once by the FSM.
- Funct decode stays inline in the FSM.

Test Plan:
- SLL: funct=0x00, shamt=4, rt=0x0000_00F1, STEP=1 → busy 5 cycles, done in 5th cycle after accept, result=0x0000_0F10, illegal=0.
- SRAV: funct=0x07, rs=0xFFFF_FFE3 (amount 3), rt=0x8000_0010 → result=0xF000_0002; with STEP=2, done after 3 cycles.
- Zero amount / illegal:
  - SRL shamt=0, rt=0x1234_5678 → done 1 cycle after accept, result=0x1234_5678.
  - funct=0x20 → done and illegal together 1 cycle after accept, result=rt.
- Busy / input hold: start pulsed during SHIFT and funct/rt toggled → ignored, original result intact; start in the cycle after done → accepted.
- Async reset mid-SHIFT (SLL 31, reset at cycle 10) → busy=0 and result=0 immediately, no done pulse; a new request then completes normally.
- With SHIFT_SEQ_ABORT_EN: SRL 16, abort at cycle 5 → IDLE next edge, result=0, done never asserted.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative MIPS shift sequencer.
package shift_seq_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;

  localparam int unsigned AMT_W = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  typedef enum logic [1:0] {OP_LEFT, OP_RIGHT_LOG, OP_RIGHT_ARITH} op_e;

  function automatic bit step_legal(input int unsigned step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

  // Width of a per-cycle shift amount able to hold 0..step.
  function automatic int unsigned amt_width(input int unsigned step);
    return $clog2(step + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Combinational single-step shifter: moves din by 0..STEP bits.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0]               din,
  input  logic [amt_width(STEP)-1:0]     amt,
  input  op_e                            op,
  output logic [WIDTH-1:0]               dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_LEFT:        dout = din << amt;
      OP_RIGHT_LOG:   dout = din >> amt;
      OP_RIGHT_ARITH: dout = $unsigned($signed(din) >>> amt);
      default:        dout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: shifts rt by up to STEP bits per cycle.
// Optional macro SHIFT_SEQ_ABORT_EN adds an abort input.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned AW = amt_width(STEP);
  localparam logic [AMT_W-1:0] STEP_C = AMT_W'(STEP);

  if (!step_legal(STEP)) begin : g_step_check
    $error("shift_sequencer: STEP must be 1, 2, 4 or 8");
  end

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic               illegal_q, illegal_d;
  logic [AMT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;

  op_e                dec_op;
  logic [AMT_W-1:0]   dec_amt;
  logic               dec_legal;
  logic [AW-1:0]      step_amt;
  logic [WIDTH-1:0]   step_out;
  logic               rs_unused;

  always_comb rs_unused = ^rs_val[WIDTH-1:AMT_W];

  always_comb begin
    dec_op    = OP_LEFT;
    dec_amt   = shamt;
    dec_legal = 1'b1;
    case (funct)
      FUNCT_SLL:  dec_op = OP_LEFT;
      FUNCT_SRL:  dec_op = OP_RIGHT_LOG;
      FUNCT_SRA:  dec_op = OP_RIGHT_ARITH;
      FUNCT_SLLV: begin dec_op = OP_LEFT;        dec_amt = rs_val[AMT_W-1:0]; end
      FUNCT_SRLV: begin dec_op = OP_RIGHT_LOG;   dec_amt = rs_val[AMT_W-1:0]; end
      FUNCT_SRAV: begin dec_op = OP_RIGHT_ARITH; dec_amt = rs_val[AMT_W-1:0]; end
      default:    dec_legal = 1'b0;
    endcase
  end

  // Last step may be shorter than STEP: s = min(STEP, count).
  always_comb begin
    step_amt = AW'(STEP);
    if (count_q < STEP_C) step_amt = count_q[AW-1:0];
  end

  shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .din  (result_q),
    .amt  (step_amt),
    .op   (op_q),
    .dout (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_LEFT;
      illegal_q <= 1'b0;
      count_q   <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = dec_op;
          illegal_d = !dec_legal;
          count_d   = dec_legal ? dec_amt : '0;
          result_d  = rt_val;
          state_d   = (!dec_legal || dec_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = step_out;
        count_d  = count_q - AMT_W'(step_amt);
        if (count_d == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SHIFT_SEQ_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      count_d   = '0;
      result_d  = '0;
      illegal_d = 1'b0;
    end
`endif
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    illegal = (state_q == DONE) && illegal_q;
    result  = result_q;
  end

endmodule
